ecc_mod_inv: RTL and testbench
==============================

ECC_MOD_INV -- requirements
Module: ecc_mod_inv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, giving the operand/modulus width in bits (legal range 8..521).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  one-cycle request strobe qualifying a and n.
REQ-005 The block SHALL have port a  input  WIDTH  value to invert.
REQ-006 The block SHALL have port n  input  WIDTH  modulus (curve order or field prime).
REQ-007 The block SHALL have port result  output  WIDTH  a^-1 mod n, valid while out_valid=1.
REQ-008 The block SHALL have port out_valid  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have port fail  output  1  no inverse exists or request illegal; valid while out_valid=1.
REQ-010 The block SHALL have port busy  output  1  high from request acceptance until the cycle out_valid is asserted, inclusive.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on accepted in_valid, CALC->DONE on termination, DONE->IDLE unconditionally after one cycle.
REQ-012 in_valid SHALL be accepted only in IDLE; in_valid during CALC or DONE SHALL be ignored with no effect on the running operation.
REQ-013 On acceptance, if n[0]=0, n<3, a=0 or a>=n, the block SHALL go directly to DONE with fail=1, result=0 (out_valid on the cycle after acceptance).
REQ-014 Otherwise on acceptance registers SHALL load u=a, v=n, x1=1, x2=0, latching n internally (later changes on a/n have no effect).
REQ-015 Each CALC cycle SHALL perform exactly one step in priority order: u=1 -> result=x1, done; v=1 -> result=x2, done; u=0 -> fail=1, result=0, done; u even -> u=u/2, x1=x1/2 if even else (x1+n)/2; v even -> v=v/2, x2 likewise; u>=v -> u=u-v, x1=(x1-x2) mod n; else v=v-u, x2=(x2-x1) mod n.
REQ-016 x1+n SHALL be computed at WIDTH+1 bits before halving; modular subtraction SHALL add n when the raw difference is negative; x1, x2 SHALL remain in [0, n-1].
REQ-017 Latency from acceptance edge to out_valid SHALL be at most 4*WIDTH+2 cycles for all legal inputs; a=1 SHALL give out_valid exactly 2 cycles after acceptance.
REQ-018 out_valid SHALL be high for exactly one cycle (state DONE); result and fail SHALL hold their values until the next acceptance.
REQ-019 A new in_valid SHALL be accepted in the cycle immediately following out_valid (back-to-back operation, no dead cycle beyond DONE).

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE, result=0, out_valid=0, fail=0, busy=0 and clear u, v, x1, x2, iteration counter.
REQ-021 Reset asserted mid-CALC SHALL abort the operation with no out_valid pulse; first request after release SHALL be processed normally.

Configuration
REQ-022 Macro ECC_INV_TIMEOUT_EN SHALL control a step-count watchdog.
REQ-023 With ECC_INV_TIMEOUT_EN defined, a counter SHALL count CALC cycles and, on reaching 4*WIDTH+4 without termination, SHALL force DONE with fail=1, result=0.
REQ-024 Without ECC_INV_TIMEOUT_EN, no counter SHALL be synthesised and CALC SHALL exit only through REQ-015 terminations.

Verification
REQ-025 WIDTH=8, n=11, a=3 -> one out_valid pulse, result=4, fail=0, within 34 cycles.
REQ-026 WIDTH=8, n=15, a=5 -> out_valid, fail=1, result=0 (gcd=5); n=11, a=12 -> fail=1 one cycle after acceptance; a=0 -> fail=1.
REQ-027 WIDTH=256, n=secp256k1 order, a=1 -> result=1 two cycles after acceptance; 1000 random a in [1,n-1] -> result*a mod n = 1, latency <= 1026.
REQ-028 WIDTH=8, n=11, a=3 accepted, in_valid pulsed with a=2 during CALC -> result=4 only, no second out_valid; request a=2 the cycle after out_valid -> result=6.
REQ-029 Assert rst_n=0 for one cycle mid-CALC -> all outputs 0 immediately, no out_valid; then n=11, a=7 -> result=8.
REQ-030 With ECC_INV_TIMEOUT_EN, stalled iteration forced via bench force on u (u held at 2) -> fail=1 after 4*WIDTH+4 CALC cycles; without the macro, normal results of REQ-025..029 unchanged.

Source files
------------

// File: rtl/ecc_mod_inv_if.sv
// Request/response bundle for the modular inverter.
// Handshake: in_valid is a one-cycle strobe, taken only while busy=0; result/fail are valid on out_valid.
interface ecc_mod_inv_if #(parameter int WIDTH = 256);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             fail;
    logic             busy;

    modport master (output in_valid, a, n, input result, out_valid, fail, busy);
    modport slave  (input in_valid, a, n, output result, out_valid, fail, busy);
endinterface

// File: rtl/ecc_mod_inv.sv
// Binary extended-Euclid modular inverter, one reduction step per clock.
// Define ECC_INV_TIMEOUT_EN to add a step-count watchdog that forces a failed completion.
module ecc_mod_inv #(
    parameter int WIDTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    ecc_mod_inv_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] u, v, x1, x2, nr;
    logic [WIDTH-1:0] result_r;
    logic             out_valid_r, fail_r, busy_r;
    logic             illegal;

`ifdef ECC_INV_TIMEOUT_EN
    localparam int LIMIT = 4 * WIDTH + 4;
    localparam int CNT_W = $clog2(LIMIT);
    logic [CNT_W-1:0] step_cnt;
`endif

    // Halve modulo m: odd values get m added first, at WIDTH+1 bits so the carry survives.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[WIDTH]) d = d + {1'b0, m};
        return d[WIDTH-1:0];
    endfunction

    assign illegal = !bus.n[0] || (bus.n < WIDTH'(3)) || (bus.a == '0) || (bus.a >= bus.n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            u           <= '0;
            v           <= '0;
            x1          <= '0;
            x2          <= '0;
            nr          <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
            fail_r      <= 1'b0;
            busy_r      <= 1'b0;
`ifdef ECC_INV_TIMEOUT_EN
            step_cnt    <= '0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        busy_r   <= 1'b1;
                        result_r <= '0;
                        fail_r   <= 1'b0;
                        if (illegal) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            fail_r      <= 1'b1;
                        end else begin
                            state <= CALC;
                            u     <= bus.a;
                            v     <= bus.n;
                            x1    <= ONE;
                            x2    <= '0;
                            nr    <= bus.n;
`ifdef ECC_INV_TIMEOUT_EN
                            step_cnt <= '0;
`endif
                        end
                    end
                end
                CALC: begin
                    state       <= DONE;
                    out_valid_r <= 1'b1;
                    if (u == ONE) begin
                        result_r <= x1;
                    end else if (v == ONE) begin
                        result_r <= x2;
                    end else if (u == '0) begin
                        result_r <= '0;
                        fail_r   <= 1'b1;
`ifdef ECC_INV_TIMEOUT_EN
                    end else if (step_cnt == CNT_W'(LIMIT - 1)) begin
                        result_r <= '0;
                        fail_r   <= 1'b1;
`endif
                    end else begin
                        // Not terminating: stay in CALC and perform one reduction step.
                        state       <= CALC;
                        out_valid_r <= 1'b0;
`ifdef ECC_INV_TIMEOUT_EN
                        step_cnt    <= step_cnt + 1'b1;
`endif
                        if (!u[0]) begin
                            u  <= u >> 1;
                            x1 <= half_mod(x1, nr);
                        end else if (!v[0]) begin
                            v  <= v >> 1;
                            x2 <= half_mod(x2, nr);
                        end else if (u >= v) begin
                            u  <= u - v;
                            x1 <= sub_mod(x1, x2, nr);
                        end else begin
                            v  <= v - u;
                            x2 <= sub_mod(x2, x1, nr);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result    = result_r;
    assign bus.out_valid = out_valid_r;
    assign bus.fail      = fail_r;
    assign bus.busy      = busy_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_ecc_mod_inv.sv
// Directed bench for ecc_mod_inv: brute-force inverse model at WIDTH=8, product check at WIDTH=256.
module tb_ecc_mod_inv;

    localparam logic [255:0] N256 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    typedef struct packed {
        logic [7:0]  res;
        logic        fl;
        logic [31:0] acc;
        logic [15:0] lat;
        logic        exact;
    } exp8_t;

    typedef struct packed {
        logic [255:0] a;
        logic [31:0]  acc;
        logic [15:0]  lat;
        logic         exact;
    } exp256_t;

    logic clk;
    logic rst_n;
    logic [1:0] st8, st256;
    int cyc;
    int checks;
    int failures;
    exp8_t   exp_q[$];
    exp256_t exp_q256[$];
    logic [7:0] held_res8;
    logic       held_fail8;

    ecc_mod_inv_if #(.WIDTH(8))   bus8();
    ecc_mod_inv_if #(.WIDTH(256)) bus256();

    ecc_mod_inv #(.WIDTH(8))   dut8   (.clk(clk), .rst_n(rst_n), .bus(bus8),   .dbg_state(st8));
    ecc_mod_inv #(.WIDTH(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(bus256), .dbg_state(st256));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- helpers / model ----------------
    task automatic check(input bit ok, input string name,
                         input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit illegal8(input int av, input int nv);
        return (nv % 2 == 0) || (nv < 3) || (av == 0) || (av >= nv);
    endfunction

    // {fail, result}: search for x with a*x = 1 (mod n).
    function automatic logic [8:0] inv_model(input int av, input int nv);
        if (illegal8(av, nv)) return {1'b1, 8'd0};
        for (int x = 1; x < nv; x++)
            if ((av * x) % nv == 1) return {1'b0, 8'(x)};
        return {1'b1, 8'd0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic start8(input int av, input int nv, input bit push);
        exp8_t e;
        logic [8:0] m;
        bus8.in_valid = 1'b1;
        bus8.a = 8'(av);
        bus8.n = 8'(nv);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        check(bus8.busy == 1'b1, "busy_after_accept8", 256'(bus8.busy), 256'd1);
        if (push) begin
            m       = inv_model(av, nv);
            e.res   = m[7:0];
            e.fl    = m[8];
            e.acc   = cyc;
            e.exact = illegal8(av, nv) || (av == 1);
            e.lat   = illegal8(av, nv) ? 16'd1 : (av == 1) ? 16'd2 : 16'd34;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done8(input int budget);
        for (int i = 0; i < budget; i++) begin
            sync();
            if (exp_q.size() == 0) return;
        end
        check(1'b0, "done_timeout8", 256'(exp_q.size()), 256'd0);
        exp_q.delete();
    endtask

    task automatic req8(input int av, input int nv);
        start8(av, nv, 1'b1);
        wait_done8(60);
    endtask

    task automatic req256(input logic [255:0] av, input bit exact);
        exp256_t e;
        bus256.in_valid = 1'b1;
        bus256.a = av;
        bus256.n = N256;
        @(posedge clk);
        #1;
        bus256.in_valid = 1'b0;
        e.a     = av;
        e.acc   = cyc;
        e.exact = exact;
        e.lat   = exact ? 16'd2 : 16'd1026;
        exp_q256.push_back(e);
        for (int i = 0; i < 1100; i++) begin
            sync();
            if (exp_q256.size() == 0) return;
        end
        check(1'b0, "done_timeout256", 256'(exp_q256.size()), 256'd0);
        exp_q256.delete();
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            held_res8  = 8'd0;
            held_fail8 = 1'b0;
        end else begin
            if (bus8.out_valid) begin
                check(exp_q.size() != 0, "unexpected_out8", 256'd1, 256'd0);
                check(bus8.busy == 1'b1, "busy_at_out8", 256'(bus8.busy), 256'd1);
                if (exp_q.size() != 0) begin
                    exp8_t e;
                    int lat;
                    e   = exp_q.pop_front();
                    lat = cyc - int'(e.acc) + 1;
                    check(bus8.result == e.res, "result8", 256'(bus8.result), 256'(e.res));
                    check(bus8.fail == e.fl, "fail8", 256'(bus8.fail), 256'(e.fl));
                    if (e.exact)
                        check(lat == int'(e.lat), "latency_exact8", 256'(lat), 256'(e.lat));
                    else
                        check(lat <= int'(e.lat), "latency_max8", 256'(lat), 256'(e.lat));
                    held_res8  = e.res;
                    held_fail8 = e.fl;
                end
            end else if (!bus8.busy) begin
                check(bus8.result == held_res8, "hold_result8", 256'(bus8.result), 256'(held_res8));
                check(bus8.fail == held_fail8, "hold_fail8", 256'(bus8.fail), 256'(held_fail8));
            end
            if (bus256.out_valid) begin
                check(exp_q256.size() != 0, "unexpected_out256", 256'd1, 256'd0);
                if (exp_q256.size() != 0) begin
                    exp256_t e;
                    logic [511:0] prod;
                    int lat;
                    e    = exp_q256.pop_front();
                    lat  = cyc - int'(e.acc) + 1;
                    prod = ({256'd0, bus256.result} * {256'd0, e.a}) % {256'd0, N256};
                    check(bus256.fail == 1'b0, "fail256", 256'(bus256.fail), 256'd0);
                    check(bus256.result < N256, "range256", bus256.result, N256);
                    check(prod == 512'd1, "inverse256", prod[255:0], 256'd1);
                    if (e.exact)
                        check(lat == int'(e.lat), "latency_exact256", 256'(lat), 256'(e.lat));
                    else
                        check(lat <= int'(e.lat), "latency_max256", 256'(lat), 256'(e.lat));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int tab_a[12] = '{3, 5, 12, 0, 1, 10, 2, 1, 200, 254, 85, 128};
    int tab_n[12] = '{11, 15, 11, 11, 11, 11, 10, 1, 251, 255, 255, 255};

    initial begin
        logic [8:0] m;
        logic [255:0] ra;
        cyc = 0;
        checks = 0;
        failures = 0;
        held_res8 = 8'd0;
        held_fail8 = 1'b0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.n = '0;
        bus256.in_valid = 1'b0;
        bus256.a = '0;
        bus256.n = '0;

        // Hand-computed pins on the model itself.
        m = inv_model(3, 11);   check(m == {1'b0, 8'd4}, "model_3_11", 256'(m), 256'h004);
        m = inv_model(2, 11);   check(m == {1'b0, 8'd6}, "model_2_11", 256'(m), 256'h006);
        m = inv_model(7, 11);   check(m == {1'b0, 8'd8}, "model_7_11", 256'(m), 256'h008);
        m = inv_model(5, 15);   check(m == {1'b1, 8'd0}, "model_5_15", 256'(m), 256'h100);
        m = inv_model(12, 11);  check(m == {1'b1, 8'd0}, "model_12_11", 256'(m), 256'h100);

        repeat (3) @(posedge clk);
        #1;
        check(bus8.result == 8'd0 && bus8.out_valid == 1'b0 && bus8.fail == 1'b0 && bus8.busy == 1'b0,
              "reset_outputs8", 256'({bus8.result, bus8.out_valid, bus8.fail, bus8.busy}), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sync();

        // Directed table: legal, non-invertible, illegal and boundary operands.
        for (int i = 0; i < 12; i++) req8(tab_a[i], tab_n[i]);

        // Assorted operands over prime and composite odd moduli.
        for (int i = 0; i < 10; i++) req8($urandom_range(1, 250), 251);
        for (int i = 0; i < 10; i++) req8($urandom_range(0, 255), $urandom_range(1, 127) * 2 + 1);

        // In-flight request is ignored, then a back-to-back request right after completion.
        start8(3, 11, 1'b1);
        sync();
        bus8.in_valid = 1'b1;
        bus8.a = 8'd2;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        wait_done8(60);
        req8(2, 11);

        // Reset in the middle of a calculation aborts it silently.
        start8(3, 11, 1'b0);
        sync();
        rst_n = 1'b0;
        #1;
        check(bus8.result == 8'd0 && bus8.out_valid == 1'b0 && bus8.fail == 1'b0 && bus8.busy == 1'b0,
              "reset_midcalc8", 256'({bus8.result, bus8.out_valid, bus8.fail, bus8.busy}), 256'd0);
        check(st8 == 2'd0, "reset_state8", 256'(st8), 256'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) sync();
        req8(7, 11);

`ifdef ECC_INV_TIMEOUT_EN
        // Stalled iteration: u pinned at 2 never terminates, so the watchdog must fire.
        begin
            exp8_t e;
            start8(3, 11, 1'b0);
            force dut8.u = 8'd2;
            e.res = 8'd0;
            e.fl = 1'b1;
            e.acc = cyc;
            e.exact = 1'b1;
            e.lat = 16'(4 * 8 + 5);
            exp_q.push_back(e);
            wait_done8(80);
            release dut8.u;
        end
        req8(3, 11);
`endif

        // Wide operand: secp256k1 group order.
        req256(256'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ra = ra % (N256 - 256'd1) + 256'd1;
            req256(ra, 1'b0);
        end

        repeat (3) sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
